// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between N masters and the round-robin arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface round_robin_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int IDW       = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0] req_i;
    logic [NUM_PORTS-1:0] lock_i;
    logic [NUM_PORTS-1:0] gnt_o;
    logic                 gnt_valid_o;
    logic [IDW-1:0]       gnt_id_o;

    modport master (
        output req_i, lock_i,
        input  gnt_o, gnt_valid_o, gnt_id_o
    );

    modport slave (
        input  req_i, lock_i,
        output gnt_o, gnt_valid_o, gnt_id_o
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with burst locking and an optional cap on lock length.
// Grant is combinational from requests and the registered pointer/lock state.
module round_robin_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_LOCK  = 4,
    localparam int IDW      = $clog2(NUM_PORTS),
    localparam int CW       = $clog2(MAX_LOCK + 2)
) (
    input  logic               clk,
    input  logic               reset,
    round_robin_arbiter_if.slave bus
);
    logic [IDW-1:0] ptr_q;
    logic           locked_q;
    logic [IDW-1:0] owner_q;
    logic [CW-1:0]  lock_cnt_q;

    logic           cont_lock;
    logic           found;
    logic [IDW-1:0] start;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] win;
    logic [IDW-1:0] nxt;
    logic           keep_lock;

    always_comb begin
        cont_lock = locked_q && bus.req_i[owner_q];
        start     = ptr_q;
        found     = 1'b0;
        win       = '0;
        cand      = '0;
        // An abandoned lock hands priority to the port after the owner right away.
        if (locked_q && !cont_lock)
            start = IDW'((int'(owner_q) + 1) % NUM_PORTS);
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = IDW'((int'(start) + i) % NUM_PORTS);
            if (!found && bus.req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (cont_lock) begin
            found = 1'b1;
            win   = owner_q;
        end
        nxt       = IDW'((int'(win) + 1) % NUM_PORTS);
        keep_lock = bus.lock_i[owner_q] &&
                    ((MAX_LOCK == 0) || (int'(lock_cnt_q) + 1 < MAX_LOCK));
    end

    assign bus.gnt_valid_o = found && !reset;
    assign bus.gnt_o       = bus.gnt_valid_o ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << win) : '0;
    assign bus.gnt_id_o    = bus.gnt_valid_o ? win : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else if (!found) begin
            locked_q <= 1'b0;
        end else if (cont_lock) begin
            if (keep_lock) begin
                if (lock_cnt_q != '1)
                    lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
                // Owner release or cap reached: rotate past the owner.
                locked_q   <= 1'b0;
                lock_cnt_q <= '0;
                ptr_q      <= nxt;
            end
        end else if (bus.lock_i[win] && (MAX_LOCK != 1)) begin
            locked_q   <= 1'b1;
            owner_q    <= win;
            lock_cnt_q <= CW'(1);
        end else begin
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
            ptr_q      <= nxt;
        end
    end
endmodule
